// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
//   Bit-serial-by-nibble ALU: one 74181-style 4-bit slice is reused once per
//   cycle, LSB slice first, to produce a WIDTH-bit result. The result is
//   identical to NSLICE slices ripple-cascaded combinationally.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   ena             clock enable; all state holds when low
//   start           request an operation (taken only in IDLE)
//   acc             1 = use current f as the A operand instead of port a
//   a, b            operands (WIDTH bits)
//   s, m, cin       74181 function select, mode (1 = logic), cn (active-low carry)
//   f, cout, equal  registered result, final cn4, AND of slice A=B outputs
//   busy, done      operation in progress, one-cycle completion pulse

// Single 4-bit 74181 slice, active-high data convention.
//   a, b   4-bit operands      s, m, cn  function select, mode, carry in (active low)
//   f      4-bit result        cn4       carry out (active low)
//   aeqb   high when f is all ones
module alu_74181 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       cn,
   output logic [3:0] f,
   output logic       cn4,
   output logic       aeqb
);
   logic [3:0] g, p;
   logic [4:0] c;

   always_comb begin
      // g is always a subset of p, so arithmetic mode computes p + g + carry.
      g    = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
      p    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
      c    = '0;
      c[0] = ~cn;
      for (int i = 0; i < 4; i++) c[i+1] = g[i] | (p[i] & c[i]);
      f    = m ? ~(p ^ g) : (p ^ g ^ c[3:0]);
      cn4  = ~c[4];
      aeqb = &f;
   end
endmodule

module alu_slice_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic             acc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             cin,
   output logic [WIDTH-1:0] f,
   output logic             cout,
   output logic             equal,
   output logic             busy,
   output logic             done
);
   localparam int NSLICE = WIDTH / 4;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   generate
      if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
         $error("alu_slice_sequencer: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_next;

   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] op_a, op_b, work, work_next;
   logic [3:0]       op_s;
   logic             op_m, op_cin, carry, eq_acc;
   logic [3:0]       sl_a, sl_b, sl_f;
   logic             sl_cn, sl_cn4, sl_eq, last;

   // Select the operand nibbles of the current slice.
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx == IW'(i)) begin
            sl_a = op_a[4*i +: 4];
            sl_b = op_b[4*i +: 4];
         end
      end
   end

   // Working register with the current slice result merged in; loaded into f
   // directly on the last slice so the final nibble is included.
   always_comb begin
      work_next = work;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx == IW'(i)) work_next[4*i +: 4] = sl_f;
      end
   end

   assign sl_cn = (idx == '0) ? op_cin : carry;
   assign last  = (idx == IW'(NSLICE - 1));
   assign busy  = (state == BUSY);

   alu_74181 u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .s    (op_s),
      .m    (op_m),
      .cn   (sl_cn),
      .f    (sl_f),
      .cn4  (sl_cn4),
      .aeqb (sl_eq)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (ena) begin
         case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last)  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         op_s   <= '0;
         op_m   <= 1'b0;
         op_cin <= 1'b0;
         work   <= '0;
         carry  <= 1'b0;
         eq_acc <= 1'b0;
         f      <= '0;
         cout   <= 1'b0;
         equal  <= 1'b0;
         done   <= 1'b0;
      end else begin
         // done clears on the following edge even when ena is low.
         done <= 1'b0;
         if (ena) begin
            if (state == IDLE && start) begin
               op_a   <= acc ? f : a;
               op_b   <= b;
               op_s   <= s;
               op_m   <= m;
               op_cin <= cin;
               idx    <= '0;
               eq_acc <= 1'b1;
            end else if (state == BUSY) begin
               work   <= work_next;
               carry  <= sl_cn4;
               eq_acc <= eq_acc & sl_eq;
               idx    <= idx + 1'b1;
               if (last) begin
                  idx   <= '0;
                  f     <= work_next;
                  cout  <= sl_cn4;
                  equal <= eq_acc & sl_eq;
                  done  <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Testbench for alu_slice_sequencer: four instances (WIDTH 4/8/16/32) share
// stimulus. Directed table and corner sequences target the 16-bit instance;
// random operations are compared on all four against a whole-word model.
module tb_alu_slice_sequencer;
   localparam int NW = 4;
   localparam int WS [NW] = '{4, 8, 16, 32};
   localparam int D16 = 2;

   logic clk = 1'b0, rst = 1'b0, ena = 1'b0, start = 1'b0, acc = 1'b0;
   logic m = 1'b0, cin = 1'b1;
   logic [31:0] a_in = '0, b_in = '0;
   logic [3:0]  s = '0;

   logic [31:0]   fo [NW];
   logic [NW-1:0] co, eqo, bsy, dn;

   generate
      for (genvar gi = 0; gi < NW; gi++) begin : g_dut
         localparam int W = WS[gi];
         logic [W-1:0] fl;
         alu_slice_sequencer #(.WIDTH(W)) u_dut (
            .clk(clk), .rst(rst), .ena(ena), .start(start), .acc(acc),
            .a(a_in[W-1:0]), .b(b_in[W-1:0]), .s(s), .m(m), .cin(cin),
            .f(fl), .cout(co[gi]), .equal(eqo[gi]), .busy(bsy[gi]), .done(dn[gi])
         );
         assign fo[gi] = 32'(fl);
      end
   endgenerate

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Whole-word reference: arithmetic mode is P + G + carry over the full
   // width, logic mode is ~(P ^ G); equal is "result all ones".
   function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] fs, input logic fm, input logic fcin);
      logic [63:0] mask, p, g, sum;
      logic [31:0] fr;
      logic        c;
      mask = (64'd1 << w) - 64'd1;
      p    = {32'd0, a | (b & {32{fs[0]}}) | (~b & {32{fs[1]}})} & mask;
      g    = {32'd0, (a & ~b & {32{fs[2]}}) | (a & b & {32{fs[3]}})} & mask;
      sum  = p + g + {63'd0, ~fcin};
      c    = ~sum[w];
      fr   = fm ? 32'(~(p ^ g) & mask) : 32'(sum & mask);
      return {(fr == 32'(mask)), c, fr};
   endfunction

   typedef struct {
      logic [15:0] a, b;
      logic [3:0]  s;
      logic        m, cin, acc;
      logic [15:0] ef;
      logic        ec, eeq;
   } vec_t;

   vec_t tbl [11];

   task automatic run16(input vec_t v, input string tag);
      logic [15:0] prev;
      int cyc, bcnt;
      logic held;
      prev = fo[D16][15:0];
      a_in = {16'h0, v.a}; b_in = {16'h0, v.b};
      s = v.s; m = v.m; cin = v.cin; acc = v.acc;
      start = 1'b1;
      step;
      start = 1'b0;
      cyc = 0; bcnt = 0; held = 1'b1;
      while (!dn[D16] && cyc < 40) begin
         if (bsy[D16]) bcnt++;
         if (fo[D16][15:0] !== prev) held = 1'b0;
         step;
         cyc++;
      end
      acc = 1'b0;
      chk({tag, " latency"}, 64'(cyc), 64'd4);
      chk({tag, " busy_cycles"}, 64'(bcnt), 64'd4);
      chk({tag, " f_held"}, 64'(held), 64'd1);
      chk({tag, " f"}, 64'(fo[D16]), 64'(v.ef));
      chk({tag, " cout"}, 64'(co[D16]), 64'(v.ec));
      chk({tag, " equal"}, 64'(eqo[D16]), 64'(v.eeq));
      chk({tag, " busy_at_done"}, 64'(bsy[D16]), 64'd0);
   endtask

   initial begin
      logic [33:0] exp [NW];
      logic [31:0] ef [NW];
      logic [31:0] ra, rb;
      int first [NW];
      int ndn [NW];
      int cyc, cnt;

      tbl[0]  = '{16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h2233, 1'b1, 1'b0};
      tbl[1]  = '{16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1};
      tbl[2]  = '{16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0};
      tbl[3]  = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b0, 16'h0FF0, 1'b1, 1'b0};
      tbl[4]  = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 1'b0, 16'h0FF0, 1'b1, 1'b0};
      tbl[5]  = '{16'h0001, 16'h0000, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
      tbl[6]  = '{16'hABCD, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
      tbl[7]  = '{16'h0000, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b0};
      tbl[8]  = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0};
      tbl[9]  = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[10] = '{16'h00FF, 16'h0000, 4'b1001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0};

      // Reset state
      #2 rst = 1'b1;
      step; step;
      for (int i = 0; i < NW; i++) begin
         chk($sformatf("reset w%0d f", WS[i]), 64'(fo[i]), 64'd0);
         chk($sformatf("reset w%0d flags", WS[i]), 64'({co[i], eqo[i], bsy[i], dn[i]}), 64'd0);
      end
      rst = 1'b0;
      ena = 1'b1;
      step;

      // Directed table, back to back
      for (int t = 0; t < 11; t++) run16(tbl[t], $sformatf("vec%0d", t));

      // Start mid-op with changed operands, plus ena low for two cycles
      a_in = 32'h1234; b_in = 32'h0FFF; s = 4'b1001; m = 1'b0; cin = 1'b1; acc = 1'b0;
      start = 1'b1;
      step;
      start = 1'b0;
      cyc = 0;
      while (!dn[D16] && cyc < 40) begin
         start = 1'b0; ena = 1'b1;
         if (cyc == 1) begin
            a_in = 32'hFFFF; b_in = 32'hFFFF; s = 4'b0110; m = 1'b1; start = 1'b1;
         end
         if (cyc == 2 || cyc == 3) ena = 1'b0;
         step;
         cyc++;
      end
      start = 1'b0; ena = 1'b1;
      chk("stall latency", 64'(cyc), 64'd6);
      chk("stall f", 64'(fo[D16]), 64'h2233);
      chk("stall cout", 64'(co[D16]), 64'd1);
      ena = 1'b0;
      step;
      chk("done clears with ena low", 64'(dn[D16]), 64'd0);
      chk("f holds after done", 64'(fo[D16]), 64'h2233);
      ena = 1'b1;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (dn[D16] || bsy[D16]) cnt++;
         step;
      end
      chk("no queued start", 64'(cnt), 64'd0);

      // Reset in the middle of an operation
      a_in = 32'h1111; b_in = 32'h2222; s = 4'b1001; m = 1'b0; cin = 1'b1;
      start = 1'b1;
      step;
      start = 1'b0;
      step; step;
      #2 rst = 1'b1;
      #1;
      chk("async reset f", 64'(fo[D16]), 64'd0);
      chk("async reset flags", 64'({co[D16], eqo[D16], bsy[D16], dn[D16]}), 64'd0);
      step;
      rst = 1'b0;
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (dn[D16]) cnt++;
         step;
      end
      chk("no done after abort", 64'(cnt), 64'd0);
      run16('{16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h3333, 1'b1, 1'b0}, "post_reset");

      // Random operations on all widths against the whole-word model
      rst = 1'b1;
      step;
      rst = 1'b0;
      for (int i = 0; i < NW; i++) ef[i] = '0;
      for (int it = 0; it < 40; it++) begin
         ra  = $urandom;
         rb  = $urandom;
         s   = 4'($urandom_range(0, 15));
         m   = 1'($urandom_range(0, 1));
         cin = 1'($urandom_range(0, 1));
         acc = ($urandom_range(0, 3) == 0);
         a_in = ra; b_in = rb;
         for (int i = 0; i < NW; i++) begin
            exp[i] = ref_op(WS[i], acc ? ef[i] : ra, rb, s, m, cin);
            first[i] = -1;
            ndn[i] = 0;
         end
         start = 1'b1;
         step;
         start = 1'b0;
         for (int c = 1; c <= 10; c++) begin
            step;
            for (int i = 0; i < NW; i++) begin
               if (dn[i]) begin
                  ndn[i]++;
                  if (first[i] < 0) first[i] = c;
               end
            end
         end
         for (int i = 0; i < NW; i++) begin
            chk($sformatf("rnd%0d w%0d latency", it, WS[i]), 64'(first[i]), 64'(WS[i] / 4));
            chk($sformatf("rnd%0d w%0d done_count", it, WS[i]), 64'(ndn[i]), 64'd1);
            chk($sformatf("rnd%0d w%0d f", it, WS[i]), 64'(fo[i]), 64'(exp[i][31:0]));
            chk($sformatf("rnd%0d w%0d cout", it, WS[i]), 64'(co[i]), 64'(exp[i][32]));
            chk($sformatf("rnd%0d w%0d equal", it, WS[i]), 64'(eqo[i]), 64'(exp[i][33]));
            ef[i] = exp[i][31:0];
         end
      end
      acc = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
